// File: rtl/cfa_frame_writer_if.sv
// cfa_frame_writer_if: pixel-stream and frame-memory write bus of the CFA frame writer.
//   pixelValid/pixelReady/pixelData : RGB pixel stream into the writer, {R,G,B} with R in MSBs
//   wrEn/wrReady/wrAddress/wrData   : memory write request, address is {row,col}
// Modports:
//   master : the writer (consumes pixels, issues memory writes)
//   slave  : the environment (produces pixels, accepts memory writes)
`timescale 1ns/1ps
interface cfa_frame_writer_if #(
  parameter int unsigned rowBitWidth  = 11,
  parameter int unsigned colBitWidth  = 11,
  parameter int unsigned dataBitWidth = 8
);
  logic                                 pixelValid;
  logic                                 pixelReady;
  logic [3*dataBitWidth-1:0]            pixelData;
  logic                                 wrEn;
  logic                                 wrReady;
  logic [rowBitWidth+colBitWidth-1:0]   wrAddress;
  logic [3*dataBitWidth-1:0]            wrData;

  modport master (
    input  pixelValid, pixelData, wrReady,
    output pixelReady, wrEn, wrAddress, wrData
  );

  modport slave (
    output pixelValid, pixelData, wrReady,
    input  pixelReady, wrEn, wrAddress, wrData
  );
endinterface

// File: rtl/cfa_frame_writer.sv
// cfa_frame_writer: tags a raster-order RGB pixel stream with {row,col} and writes it to the
// output frame memory through a 2-entry FIFO; pulses done once the last write has drained.
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-low
//   start          frame start pulse, sampled only when idle
//   rowMax/colMax  last row/col index, latched on start
//   bus            pixel stream in, memory writes out (master modport)
//   busy           high while a frame is in progress or draining
//   done           one-cycle pulse when the frame is fully written
`timescale 1ns/1ps
module cfa_frame_writer #(
  parameter int unsigned rowBitWidth  = 11,
  parameter int unsigned colBitWidth  = 11,
  parameter int unsigned dataBitWidth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [rowBitWidth-1:0] rowMax,
  input  logic [colBitWidth-1:0] colMax,
  cfa_frame_writer_if.master     bus,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned PixW   = 3 * dataBitWidth;
  localparam int unsigned EntryW = rowBitWidth + colBitWidth + PixW;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e                 state_q, state_d;
  logic [rowBitWidth-1:0] row_q, row_d, row_max_q, row_max_d;
  logic [colBitWidth-1:0] col_q, col_d, col_max_q, col_max_d;
  logic [EntryW-1:0]      fifo_q [2];
  logic [EntryW-1:0]      fifo_d [2];
  logic                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic                   pixel_ready_q, pixel_ready_d;
  logic                   push, pop;

  // pixel_ready_q is only ever set in RUN, so push implies RUN.
  assign push = bus.pixelValid & pixel_ready_q;
  assign pop  = (count_q != 2'd0) & bus.wrReady;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    row_max_d = row_max_q;
    col_max_d = col_max_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (push) begin
      fifo_d[wr_ptr_q] = {row_q, col_q, bus.pixelData};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          row_max_d = rowMax;
          col_max_d = colMax;
          row_d     = '0;
          col_d     = '0;
          count_d   = 2'd0;
          wr_ptr_d  = 1'b0;
          rd_ptr_d  = 1'b0;
        end
      end
      StRun: begin
        if (push) begin
          if (col_q == col_max_q) begin
            // Counters hold on the last pixel so they never run past the maxima.
            if (row_q == row_max_q) begin
              state_d = StFlush;
            end else begin
              row_d = row_q + rowBitWidth'(1);
              col_d = '0;
            end
          end else begin
            col_d = col_q + colBitWidth'(1);
          end
        end
      end
      StFlush: begin
        if (count_d == 2'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered ready from next-state count: a full FIFO blocks input even if a pop fires.
    pixel_ready_d = (state_d == StRun) && (count_d < 2'd2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      row_q         <= '0;
      col_q         <= '0;
      row_max_q     <= '0;
      col_max_q     <= '0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      pixel_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      row_max_q     <= row_max_d;
      col_max_q     <= col_max_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pixel_ready_q <= pixel_ready_d;
    end
  end

  assign bus.pixelReady = pixel_ready_q;
  assign bus.wrEn       = (count_q != 2'd0);
  assign bus.wrAddress  = fifo_q[rd_ptr_q][EntryW-1:PixW];
  assign bus.wrData     = fifo_q[rd_ptr_q][PixW-1:0];
  assign busy           = (state_q == StRun) || (state_q == StFlush);
  assign done           = (state_q == StDone);

endmodule

// File: tb/tb_cfa_frame_writer.sv
// tb_cfa_frame_writer: directed bench for cfa_frame_writer. A negedge monitor keeps a
// scoreboard of accepted pixels (raster address derived from accept index) and compares every
// memory write against it; directed steps check reset, latency, back-pressure and frame ends.
`timescale 1ns/1ps
module tb_cfa_frame_writer;
  localparam int RW = 11;
  localparam int CW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] rowMax = '0;
  logic [CW-1:0] colMax = '0;
  logic          busy;
  logic          done;

  cfa_frame_writer_if #(.rowBitWidth(RW), .colBitWidth(CW), .dataBitWidth(DW)) bus ();

  cfa_frame_writer #(.rowBitWidth(RW), .colBitWidth(CW), .dataBitWidth(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .rowMax (rowMax),
    .colMax (colMax),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  int n_acc = 0, n_wr = 0, n_done = 0, frame_acc = 0, cur_cols = 1;
  logic [RW+CW+3*DW-1:0] exp_q[$];
  logic [RW+CW+3*DW-1:0] head;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (start && !busy && !done) begin
        frame_acc = 0;
        cur_cols  = int'(colMax) + 1;
      end
      if (bus.wrEn && bus.wrReady) begin
        n_wr++;
        check("wr_has_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          head = exp_q.pop_front();
          check("wr_addr", 64'(bus.wrAddress), 64'(head[RW+CW+3*DW-1:3*DW]));
          check("wr_data", 64'(bus.wrData), 64'(head[3*DW-1:0]));
        end
      end
      if (bus.pixelValid && bus.pixelReady) begin
        exp_q.push_back({RW'(frame_acc / cur_cols), CW'(frame_acc % cur_cols), bus.pixelData});
        frame_acc++;
        n_acc++;
      end
      if (done) n_done++;
    end
  end

  int base_acc = 0, base_wr = 0, base_done = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int r, input int c);
    rowMax    = RW'(r);
    colMax    = CW'(c);
    start     = 1'b1;
    base_acc  = n_acc;
    base_wr   = n_wr;
    base_done = n_done;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int pv_pct, input int wr_pct, input string tag);
    int cyc = 0;
    while (n_done == base_done && cyc < 3000) begin
      bus.pixelValid = ($urandom_range(99) < pv_pct);
      bus.wrReady    = ($urandom_range(99) < wr_pct);
      bus.pixelData  = 24'($urandom);
      step();
      cyc++;
    end
    bus.pixelValid = 1'b0;
    bus.wrReady    = 1'b0;
    check({tag, "_finished"}, 64'(cyc < 3000), 64'd1);
    step();
    step();
  endtask

  task automatic frame_checks(input int total, input string tag);
    check({tag, "_writes"}, 64'(n_wr - base_wr), 64'(total));
    check({tag, "_accepts"}, 64'(n_acc - base_acc), 64'(total));
    check({tag, "_done_cycles"}, 64'(n_done - base_done), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_fifo_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.pixelValid = 1'b0;
    bus.pixelData  = '0;
    bus.wrReady    = 1'b0;
    #1;
    // Reset state
    check("rst_pixelReady", 64'(bus.pixelReady), 64'd0);
    check("rst_wrEn", 64'(bus.wrEn), 64'd0);
    check("rst_wrAddress", 64'(bus.wrAddress), 64'd0);
    check("rst_wrData", 64'(bus.wrData), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    step();
    rst = 1'b1;
    step();

    // 1: 2x3 frame, free-flowing
    start_frame(1, 2);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_ready", 64'(bus.pixelReady), 64'd1);
    check("t1_no_wr_yet", 64'(bus.wrEn), 64'd0);
    bus.pixelValid = 1'b1;
    bus.wrReady    = 1'b1;
    bus.pixelData  = 24'h112233;
    step();
    check("t1_first_wrEn", 64'(bus.wrEn), 64'd1);
    check("t1_first_addr", 64'(bus.wrAddress), 64'd0);
    check("t1_first_data", 64'(bus.wrData), 64'h112233);
    run_until_done(100, 100, "t1");
    frame_checks(6, "t1");

    // 2: memory stalled for 5 cycles after start
    start_frame(1, 2);
    bus.pixelValid = 1'b1;
    bus.wrReady    = 1'b0;
    bus.pixelData  = 24'hABCDEF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_wrEn", 64'(bus.wrEn), 64'd1);
      check("t2_hold_addr", 64'(bus.wrAddress), 64'd0);
    end
    check("t2_accepts", 64'(n_acc - base_acc), 64'd2);
    check("t2_ready_full", 64'(bus.pixelReady), 64'd0);
    check("t2_no_writes", 64'(n_wr - base_wr), 64'd0);
    run_until_done(100, 100, "t2");
    frame_checks(6, "t2");

    // 3: single-pixel frame
    start_frame(0, 0);
    bus.pixelValid = 1'b1;
    bus.wrReady    = 1'b1;
    bus.pixelData  = 24'hA1B2C3;
    step();
    check("t3_wrEn", 64'(bus.wrEn), 64'd1);
    check("t3_addr", 64'(bus.wrAddress), 64'd0);
    check("t3_data", 64'(bus.wrData), 64'hA1B2C3);
    check("t3_ready_low", 64'(bus.pixelReady), 64'd0);
    bus.pixelData = 24'h0F0F0F;
    step();
    check("t3_done", 64'(done), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_wrEn_off", 64'(bus.wrEn), 64'd0);
    step();
    check("t3_done_once", 64'(done), 64'd0);
    bus.pixelValid = 1'b0;
    bus.wrReady    = 1'b0;
    step();
    frame_checks(1, "t3");

    // 4: start re-pulsed mid-frame with a bigger rowMax
    start_frame(1, 2);
    bus.pixelValid = 1'b1;
    bus.wrReady    = 1'b1;
    step();
    step();
    rowMax = RW'(5);
    start  = 1'b1;
    step();
    start = 1'b0;
    run_until_done(100, 100, "t4");
    frame_checks(6, "t4");

    // 5: reset mid-frame with FIFO occupied
    start_frame(1, 2);
    bus.pixelValid = 1'b1;
    bus.wrReady    = 1'b1;
    step();
    step();
    step();
    check("t5_accepts", 64'(n_acc - base_acc), 64'd3);
    check("t5_fifo_busy", 64'(bus.wrEn), 64'd1);
    bus.wrReady = 1'b0;
    rst = 1'b0;
    #1;
    check("t5_rst_wrEn", 64'(bus.wrEn), 64'd0);
    check("t5_rst_ready", 64'(bus.pixelReady), 64'd0);
    check("t5_rst_addr", 64'(bus.wrAddress), 64'd0);
    check("t5_rst_data", 64'(bus.wrData), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    bus.pixelValid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check("t5_no_done", 64'(n_done - base_done), 64'd0);
    start_frame(1, 2);
    run_until_done(100, 100, "t5");
    frame_checks(6, "t5");

    // 6: 8x8 frame with random valid/ready
    start_frame(7, 7);
    run_until_done(50, 50, "t6");
    frame_checks(64, "t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
